// File: rtl/bpred_unit_pkg.sv
// -----------------------------------------------------------------------------
// bpred_unit_pkg
// Shared widths, FSM state type and counter helper for the branch predictor.
// Default widths match the FE/AGEX datapath: 32-bit PCs, 256-entry PHT,
// 16-entry BTB, 2-bit saturating counters.
// -----------------------------------------------------------------------------
package bpred_unit_pkg;

  localparam int DBITS        = 32;  // PC / target width
  localparam int PTINDEXBITS  = 8;   // PHT index width (BHR has the same width)
  localparam int BTBINDEXBITS = 4;   // BTB index width
  localparam int PTENTRYBITS  = 2;   // PHT counter width

  // Value written into every counter by the init sweep: weakly not-taken.
  localparam logic [PTENTRYBITS-1:0] CTR_INIT = 2'b01;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bpred_state_e;

  // Saturating 2-bit counter step: +1 on taken, -1 on not-taken,
  // pinned at 2'b11 and 2'b00.
  function automatic logic [PTENTRYBITS-1:0] ctr_next(
    input logic [PTENTRYBITS-1:0] ctr,
    input logic                   taken
  );
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/bpred_pht.sv
// -----------------------------------------------------------------------------
// bpred_pht
// Pattern history table: 2^IDX_BITS saturating 2-bit counters.
// Ports:
//   clk_i        - clock, rising edge
//   rd_idx_i     - combinational read index (lookup path)
//   rd_ctr_o     - counter at rd_idx_i, pre-write value (no bypass)
//   init_en_i    - init sweep write enable; has priority over updates
//   init_idx_i   - entry cleared to weakly not-taken when init_en_i=1
//   upd_en_i     - training write enable
//   upd_idx_i    - entry to train
//   upd_taken_i  - resolved outcome (increment when 1, decrement when 0)
// The array has no reset; the owner is expected to run an init sweep.
// -----------------------------------------------------------------------------
module bpred_pht
  import bpred_unit_pkg::*;
#(
  parameter int IDX_BITS = PTINDEXBITS
) (
  input  logic                   clk_i,
  input  logic [IDX_BITS-1:0]    rd_idx_i,
  output logic [PTENTRYBITS-1:0] rd_ctr_o,
  input  logic                   init_en_i,
  input  logic [IDX_BITS-1:0]    init_idx_i,
  input  logic                   upd_en_i,
  input  logic [IDX_BITS-1:0]    upd_idx_i,
  input  logic                   upd_taken_i
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [PTENTRYBITS-1:0] ctr_q [ENTRIES];

  assign rd_ctr_o = ctr_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (init_en_i) begin
      ctr_q[init_idx_i] <= CTR_INIT;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= ctr_next(ctr_q[upd_idx_i], upd_taken_i);
    end
  end

endmodule

// File: rtl/bpred_unit.sv
// -----------------------------------------------------------------------------
// bpred_unit
// Gshare branch predictor with a direct-mapped BTB, answering FE next-PC
// lookups in the same cycle and trained by AGEX resolved-branch updates.
// Ports:
//   clk            - clock, rising edge
//   reset          - asynchronous, active-low
//   lookup_pc_i    - PC being fetched
//   pred_taken_o   - predict taken (combinational)
//   pred_target_o  - predicted next PC (combinational)
//   pred_pt_idx_o  - PHT index used for this lookup (carried down the pipe)
//   pred_btb_idx_o - BTB index used for this lookup
//   upd_*_i        - resolved conditional branch from AGEX
//   ready_o        - 0 while the tables are being swept, 1 in RUN
//   dbg_state_o    - current FSM state
// Handshake: upd_valid_i is a single-cycle strobe with no back-pressure.
// An update presented while ready_o=0 is discarded; in RUN it always commits
// at the next rising edge. Lookups always see pre-update table/BHR state.
// -----------------------------------------------------------------------------
module bpred_unit
  import bpred_unit_pkg::*;
#(
  parameter int PC_BITS        = DBITS,
  parameter int PT_INDEX_BITS  = PTINDEXBITS,  // must be >= BTB_INDEX_BITS
  parameter int BTB_INDEX_BITS = BTBINDEXBITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PC_BITS-1:0]        lookup_pc_i,
  output logic                      pred_taken_o,
  output logic [PC_BITS-1:0]        pred_target_o,
  output logic [PT_INDEX_BITS-1:0]  pred_pt_idx_o,
  output logic [BTB_INDEX_BITS-1:0] pred_btb_idx_o,
  input  logic                      upd_valid_i,
  input  logic [PC_BITS-1:0]        upd_pc_i,
  input  logic                      upd_taken_i,
  input  logic [PC_BITS-1:0]        upd_target_i,
  input  logic [PT_INDEX_BITS-1:0]  upd_pt_idx_i,
  output logic                      ready_o,
  output bpred_state_e              dbg_state_o
);

  localparam int TAG_BITS    = PC_BITS - BTB_INDEX_BITS - 2;
  localparam int BTB_ENTRIES = 1 << BTB_INDEX_BITS;

  // ---------------------------------------------------------------------------
  // FSM, sweep counter and global history
  // ---------------------------------------------------------------------------
  bpred_state_e               state_q, state_d;
  logic [PT_INDEX_BITS-1:0]   cnt_q, cnt_d;
  logic [PT_INDEX_BITS-1:0]   bhr_q, bhr_d;
  logic                       ready_q, ready_d;

  logic in_init;
  logic upd_en;

  assign in_init = (state_q == ST_INIT);
  assign upd_en  = (state_q == ST_RUN) && upd_valid_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bhr_d   = bhr_q;
    ready_d = ready_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + PT_INDEX_BITS'(1);
        // Last PHT entry written this cycle; the sweep covers the BTB too
        // because it is never larger than the PHT.
        if (cnt_q == '1) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (upd_valid_i) begin
          bhr_d = {bhr_q[PT_INDEX_BITS-2:0], upd_taken_i};
        end
      end
      default: begin
        state_d = ST_INIT;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      bhr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bhr_q   <= bhr_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o     = ready_q;
  assign dbg_state_o = state_q;

  // ---------------------------------------------------------------------------
  // Lookup index math
  // ---------------------------------------------------------------------------
  logic [PT_INDEX_BITS-1:0]  lk_word;
  logic [BTB_INDEX_BITS-1:0] lk_btb_idx;
  logic [TAG_BITS-1:0]       lk_tag;
  logic [PTENTRYBITS-1:0]    lk_ctr;
  logic                      lk_hit;

  assign lk_word        = lookup_pc_i[PT_INDEX_BITS+1:2];
  assign lk_btb_idx     = lookup_pc_i[BTB_INDEX_BITS+1:2];
  assign lk_tag         = lookup_pc_i[PC_BITS-1:BTB_INDEX_BITS+2];
  assign pred_pt_idx_o  = lk_word ^ bhr_q;
  assign pred_btb_idx_o = lk_btb_idx;

  // ---------------------------------------------------------------------------
  // PHT
  // ---------------------------------------------------------------------------
  bpred_pht #(
    .IDX_BITS (PT_INDEX_BITS)
  ) u_pht (
    .clk_i       (clk),
    .rd_idx_i    (pred_pt_idx_o),
    .rd_ctr_o    (lk_ctr),
    .init_en_i   (in_init),
    .init_idx_i  (cnt_q),
    .upd_en_i    (upd_en),
    .upd_idx_i   (upd_pt_idx_i),
    .upd_taken_i (upd_taken_i)
  );

  // ---------------------------------------------------------------------------
  // BTB: {valid, tag, target}. Only taken updates allocate/overwrite.
  // ---------------------------------------------------------------------------
  logic                  btb_valid_q [BTB_ENTRIES];
  logic [TAG_BITS-1:0]   btb_tag_q   [BTB_ENTRIES];
  logic [PC_BITS-1:0]    btb_tgt_q   [BTB_ENTRIES];

  logic [BTB_INDEX_BITS-1:0] upd_btb_idx;
  logic [TAG_BITS-1:0]       upd_tag;

  assign upd_btb_idx = upd_pc_i[BTB_INDEX_BITS+1:2];
  assign upd_tag     = upd_pc_i[PC_BITS-1:BTB_INDEX_BITS+2];

  always_ff @(posedge clk) begin
    if (in_init) begin
      btb_valid_q[cnt_q[BTB_INDEX_BITS-1:0]] <= 1'b0;
    end else if (upd_en && upd_taken_i) begin
      btb_valid_q[upd_btb_idx] <= 1'b1;
      btb_tag_q[upd_btb_idx]   <= upd_tag;
      btb_tgt_q[upd_btb_idx]   <= upd_target_i;
    end
  end

  assign lk_hit = btb_valid_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);

  // Predictions are forced not-taken until the sweep has cleared the tables.
  assign pred_taken_o  = (state_q == ST_RUN) && lk_hit && lk_ctr[1];
  assign pred_target_o = pred_taken_o ? btb_tgt_q[lk_btb_idx]
                                      : lookup_pc_i + PC_BITS'(4);

  // Word-offset bits of the update PC and the counter LSB carry no
  // prediction information.
  logic unused_bits;
  assign unused_bits = ^{upd_pc_i[1:0], lk_ctr[0]};

endmodule

// File: tb/tb_bpred_unit.sv
// -----------------------------------------------------------------------------
// tb_bpred_unit
// Bench for bpred_unit: reset/init sweep checks, scenario vector table,
// reset-abort sequence, and randomized traffic against a behavioural model.
// -----------------------------------------------------------------------------
module tb_bpred_unit;
  import bpred_unit_pkg::*;

  localparam int NPT  = 256;
  localparam int NBTB = 16;
  localparam int EXPW = 1 + 32 + 8 + 4;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk;
  logic         reset;
  logic [31:0]  lookup_pc;
  logic         pred_taken;
  logic [31:0]  pred_target;
  logic [7:0]   pred_pt_idx;
  logic [3:0]   pred_btb_idx;
  logic         upd_valid;
  logic [31:0]  upd_pc;
  logic         upd_taken;
  logic [31:0]  upd_target;
  logic [7:0]   upd_pt_idx;
  logic         ready;
  bpred_state_e dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bpred_unit dut (
    .clk            (clk),
    .reset          (reset),
    .lookup_pc_i    (lookup_pc),
    .pred_taken_o   (pred_taken),
    .pred_target_o  (pred_target),
    .pred_pt_idx_o  (pred_pt_idx),
    .pred_btb_idx_o (pred_btb_idx),
    .upd_valid_i    (upd_valid),
    .upd_pc_i       (upd_pc),
    .upd_taken_i    (upd_taken),
    .upd_target_i   (upd_target),
    .upd_pt_idx_i   (upd_pt_idx),
    .ready_o        (ready),
    .dbg_state_o    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_err    = 0;
  logic [EXPW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model
  // ---------------------------------------------------------------------------
  int          pht_m [NPT];
  bit          bv_m  [NBTB];
  logic [31:0] btag_m[NBTB];
  logic [31:0] btgt_m[NBTB];
  int          bhr_m;
  int          init_left;

  function automatic void model_reset();
    for (int i = 0; i < NPT; i++) pht_m[i] = 1;
    for (int i = 0; i < NBTB; i++) bv_m[i] = 1'b0;
    bhr_m     = 0;
    init_left = NPT;
  endfunction

  // Applied once per rising edge with the inputs driven during that cycle.
  function automatic void model_commit();
    int i;
    int b;
    if (init_left > 0) begin
      init_left--;
    end else if (upd_valid) begin
      i = int'(upd_pt_idx);
      if (upd_taken) pht_m[i] = (pht_m[i] < 3) ? pht_m[i] + 1 : 3;
      else           pht_m[i] = (pht_m[i] > 0) ? pht_m[i] - 1 : 0;
      bhr_m = (bhr_m * 2 + (upd_taken ? 1 : 0)) % NPT;
      if (upd_taken) begin
        b         = int'((upd_pc >> 2) & 32'hF);
        bv_m[b]   = 1'b1;
        btag_m[b] = upd_pc >> 6;
        btgt_m[b] = upd_target;
      end
    end
  endfunction

  // Returns {taken, target, pt_idx, btb_idx}.
  function automatic logic [EXPW-1:0] model_predict(input logic [31:0] pc);
    int          word;
    int          bidx;
    int          pti;
    bit          hit;
    bit          t;
    logic [31:0] tg;
    word = int'((pc >> 2) & 32'hFF);
    bidx = int'((pc >> 2) & 32'hF);
    pti  = word ^ bhr_m;
    hit  = bv_m[bidx] && (btag_m[bidx] == (pc >> 6));
    t    = (init_left == 0) && hit && (pht_m[pti] >= 2);
    tg   = t ? btgt_m[bidx] : pc + 32'd4;
    return {t, tg, 8'(pti), 4'(bidx)};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    upd_valid  = 1'b0;
    upd_pc     = 32'h0;
    upd_taken  = 1'b0;
    upd_target = 32'h0;
    upd_pt_idx = 8'h0;
  endtask

  task automatic drive_rand_update();
    upd_valid  = 1'($urandom_range(0, 1));
    upd_pc     = $urandom;
    upd_taken  = 1'($urandom_range(0, 1));
    upd_target = $urandom;
    upd_pt_idx = 8'($urandom);
  endtask

  // Full init sweep with random (to-be-dropped) updates; checks every cycle.
  task automatic sweep_check(input string tag, input bit rand_lookup);
    logic [31:0] pc;
    for (int i = 0; i < NPT; i++) begin
      pc        = rand_lookup ? $urandom : 32'h100;
      lookup_pc = pc;
      drive_rand_update();
      #1;
      check({tag, " ready"},  64'(ready), 64'(0));
      check({tag, " taken"},  64'(pred_taken), 64'(0));
      check({tag, " target"}, 64'(pred_target), 64'(pc + 32'd4));
      check({tag, " pt_idx"}, 64'(pred_pt_idx), 64'((pc >> 2) & 32'hFF));
      check({tag, " btb_idx"}, 64'(pred_btb_idx), 64'((pc >> 2) & 32'hF));
      step();
    end
    drive_idle();
    #1;
    check({tag, " ready after sweep"}, 64'(ready), 64'(1));
    check({tag, " state after sweep"}, 64'(dbg_state), 64'(ST_RUN));
  endtask

  // ---------------------------------------------------------------------------
  // Scenario vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [7:0]  uidx;
    logic [31:0] lpc;
    logic        et;
    logic [31:0] etgt;
    logic [7:0]  eidx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utgt, input logic [7:0] uidx,
                              input logic [31:0] lpc, input logic et,
                              input logic [31:0] etgt, input logic [7:0] eidx);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.uidx = uidx;
    v.lpc = lpc; v.et = et; v.etgt = etgt; v.eidx = eidx;
    return v;
  endfunction

  task automatic apply_vec(input int n);
    vec_t v;
    v          = tbl[n];
    lookup_pc  = v.lpc;
    upd_valid  = v.uv;
    upd_pc     = v.upc;
    upd_taken  = v.ut;
    upd_target = v.utgt;
    upd_pt_idx = v.uidx;
    #1;
    check($sformatf("vec%0d taken", n),   64'(pred_taken), 64'(v.et));
    check($sformatf("vec%0d target", n),  64'(pred_target), 64'(v.etgt));
    check($sformatf("vec%0d pt_idx", n),  64'(pred_pt_idx), 64'(v.eidx));
    check($sformatf("vec%0d btb_idx", n), 64'(pred_btb_idx), 64'((v.lpc >> 2) & 32'hF));
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  int t2_start;

  initial begin
    // Set 1: train/hit, tag miss, same-cycle collision, walk BHR back to 1.
    tbl.push_back(mk(1, 32'h100, 1, 32'h200, 8'h41, 32'h100, 0, 32'h104, 8'h40));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,   8'h00, 32'h100, 1, 32'h200, 8'h41));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,   8'h00, 32'h140, 0, 32'h144, 8'h51));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,   8'h00, 32'h100, 1, 32'h200, 8'h41));
    tbl.push_back(mk(1, 32'h100, 0, 32'hBAD0, 8'h41, 32'h100, 1, 32'h200, 8'h41));
    tbl.push_back(mk(1, 32'h0, 0, 32'hBAD0, 8'hFF, 32'h100, 0, 32'h104, 8'h42));
    tbl.push_back(mk(1, 32'h0, 0, 32'hBAD0, 8'hFF, 32'h100, 0, 32'h104, 8'h44));
    tbl.push_back(mk(1, 32'h0, 0, 32'hBAD0, 8'hFF, 32'h100, 0, 32'h104, 8'h48));
    tbl.push_back(mk(1, 32'h0, 0, 32'hBAD0, 8'hFF, 32'h100, 0, 32'h104, 8'h50));
    tbl.push_back(mk(1, 32'h0, 0, 32'hBAD0, 8'hFF, 32'h100, 0, 32'h104, 8'h60));
    tbl.push_back(mk(1, 32'h0, 0, 32'hBAD0, 8'hFF, 32'h100, 0, 32'h104, 8'h00));
    tbl.push_back(mk(1, 32'h0, 0, 32'hBAD0, 8'hFF, 32'h100, 0, 32'h104, 8'hC0));
    tbl.push_back(mk(1, 32'h4, 1, 32'h44,  8'hFE, 32'h100, 0, 32'h104, 8'h40));
    tbl.push_back(mk(0, 32'h0, 0, 32'h0,   8'h00, 32'h100, 0, 32'h104, 8'h41));
    tbl.push_back(mk(0, 32'h0, 0, 32'h0,   8'h00, 32'hFFFF_FFFC, 0, 32'h0, 8'hFE));
    // Set 2 (after re-init): counter 0x10 saturation, each check through a hit.
    t2_start = tbl.size();
    tbl.push_back(mk(1, 32'hB8, 1, 32'h500,  8'hAA, 32'hB8, 0, 32'hBC,   8'h2E));
    tbl.push_back(mk(1, 32'h4C, 1, 32'h1010, 8'h10, 32'h4C, 0, 32'h50,   8'h12));
    tbl.push_back(mk(1, 32'h5C, 1, 32'h1020, 8'h10, 32'h4C, 1, 32'h1010, 8'h10));
    tbl.push_back(mk(1, 32'h7C, 1, 32'h1030, 8'h10, 32'h5C, 1, 32'h1020, 8'h10));
    tbl.push_back(mk(1, 32'h3C, 1, 32'h1040, 8'h10, 32'h7C, 1, 32'h1030, 8'h10));
    tbl.push_back(mk(1, 32'hB8, 0, 32'hDEAD0, 8'h10, 32'h3C, 1, 32'h1040, 8'h10));
    tbl.push_back(mk(0, 32'h0,  0, 32'h0,    8'h00, 32'hB8, 1, 32'h500,  8'h10));
    tbl.push_back(mk(1, 32'h0,  0, 32'h0,    8'h10, 32'hB8, 1, 32'h500,  8'h10));
    tbl.push_back(mk(0, 32'h0,  0, 32'h0,    8'h00, 32'hB8, 0, 32'hBC,   8'h52));

    // Reset values
    reset     = 1'b1;
    lookup_pc = 32'h100;
    drive_idle();
    model_reset();
    #2 reset = 1'b0;
    #1;
    check("rst ready",  64'(ready), 64'(0));
    check("rst taken",  64'(pred_taken), 64'(0));
    check("rst target", 64'(pred_target), 64'(32'h104));
    check("rst state",  64'(dbg_state), 64'(ST_INIT));
    check("rst pt_idx", 64'(pred_pt_idx), 64'(8'h40));
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    sweep_check("init", 1'b0);

    for (int i = 0; i < t2_start; i++) apply_vec(i);

    // Reset mid-RUN aborts immediately, then reset again mid-INIT at index 100.
    lookup_pc = 32'h100;
    reset = 1'b0;
    #1;
    check("runrst ready", 64'(ready), 64'(0));
    check("runrst state", 64'(dbg_state), 64'(ST_INIT));
    check("runrst pt_idx", 64'(pred_pt_idx), 64'(8'h40));
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 100; i++) begin
      drive_rand_update();
      #1;
      check("part ready", 64'(ready), 64'(0));
      check("part pt_idx", 64'(pred_pt_idx), 64'(8'h40));
      step();
    end
    drive_idle();
    reset = 1'b0;
    #1;
    check("initrst ready", 64'(ready), 64'(0));
    check("initrst state", 64'(dbg_state), 64'(ST_INIT));
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    sweep_check("reinit", 1'b1);

    for (int i = t2_start; i < tbl.size(); i++) apply_vec(i);

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      logic [31:0]     pc;
      logic [EXPW-1:0] e;
      logic [EXPW-1:0] exp_now;
      if ($urandom_range(0, 9) == 0) pc = $urandom;
      else pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      lookup_pc = pc;
      exp_now   = model_predict(pc);
      exp_q.push_back(exp_now);
      upd_valid  = ($urandom_range(0, 3) != 0);
      upd_pc     = ($urandom_range(0, 7) == 0) ? $urandom : pc;
      upd_taken  = ($urandom_range(0, 3) != 0);
      upd_target = $urandom & 32'hFFFF_FFFC;
      upd_pt_idx = ($urandom_range(0, 3) == 0) ? 8'($urandom) : exp_now[11:4];
      #1;
      e = exp_q.pop_front();
      check("rnd taken",   64'(pred_taken), 64'(e[44]));
      check("rnd target",  64'(pred_target), 64'(e[43:12]));
      check("rnd pt_idx",  64'(pred_pt_idx), 64'(e[11:4]));
      check("rnd btb_idx", 64'(pred_btb_idx), 64'(e[3:0]));
      check("rnd ready",   64'(ready), 64'(1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
